// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP sequencer for a multicycle RV32I-style datapath.
module multicycle_control_unit #(
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  state_t st, nxt;
  logic [6:0] op_q;
  assign state = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= FETCH;
      op_q <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel, alu_a_sel,
     alu_b_sel, reg_write, wb_sel, retire, illegal} = '0;
    nxt = FETCH;
    case (st)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        nxt      = mem_ready ? DECODE : FETCH;
      end
      DECODE: nxt = opcode inside {LOAD, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, FENCE} ? EXECUTE : TRAP;
      EXECUTE: begin
        alu_a_sel = op_q == AUIPC ? 2'd1 : op_q == LUI ? 2'd2 : 2'd0;
        alu_b_sel = op_q inside {OP_IMM, LOAD, STORE, JALR, AUIPC, LUI};
        pc_write  = op_q inside {BRANCH, FENCE};
        retire    = op_q inside {BRANCH, FENCE};
        pc_sel    = {1'b0, op_q == BRANCH && branch_cond};
        nxt       = op_q inside {LOAD, STORE} ? MEM : op_q inside {BRANCH, FENCE} ? FETCH : WRITEBACK;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = op_q == STORE;
        pc_write     = mem_ready && op_q == STORE;
        retire       = mem_ready && op_q == STORE;
        nxt          = !mem_ready ? MEM : op_q == STORE ? FETCH : WRITEBACK;
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = op_q == LOAD ? 2'd1 : op_q inside {JAL, JALR} ? 2'd2 : 2'd0;
        pc_sel    = op_q == JAL ? 2'd1 : op_q == JALR ? 2'd2 : 2'd0;
        nxt       = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        nxt     = TRAP;
      end
      default: nxt = FETCH;
    endcase
    // reset silences every output except the debug state view
    if (rst || DW == 0)
      {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel, alu_a_sel,
       alu_b_sel, reg_write, wb_sel, retire, illegal} = '0;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table vectors, hand-written corner sequences and a random run against a phase-queue model.
module tb_multicycle_control_unit;
  logic clk, rst, branch_cond, mem_ready;
  logic [6:0] opcode;
  logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, alu_b_sel, reg_write, retire, illegal;
  logic [1:0] pc_sel, alu_a_sel, wb_sel;
  logic [2:0] state;
  logic [17:0] dut_v;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  localparam logic [6:0] LD = 7'b0000011, OPI = 7'b0010011, AUI = 7'b0010111, ST = 7'b0100011,
                         OPR = 7'b0110011, LUI = 7'b0110111, BR = 7'b1100011, JALR = 7'b1100111,
                         JAL = 7'b1101111, FEN = 7'b0001111;
  logic [6:0] ops [10];

  multicycle_control_unit #(.DW(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .illegal(illegal), .state(state)
  );

  assign dut_v = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel, alu_a_sel,
                  alu_b_sel, reg_write, wb_sel, retire, illegal, state};

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input logic mreq, mwe, mas, irw, pcw, input logic [1:0] pcs, aas,
                                     input logic abs, rw, input logic [1:0] wbs, input logic ret, ill,
                                     input logic [2:0] st);
    return {mreq, mwe, mas, irw, pcw, pcs, aas, abs, rw, wbs, ret, ill, st};
  endfunction

  // Model: current phase number plus the phases the instruction still has to visit.
  int ph = 0;
  int q[$];
  logic [6:0] mop = '0;

  function automatic logic legal(input logic [6:0] o);
    for (int i = 0; i < 10; i++) if (ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [17:0] model_exp();
    logic fin, alast;
    logic [1:0] pcs, aas, wbs;
    if (rst) return pk(0,0,0,0,0,0,0,0,0,0,0,0,3'(ph));
    fin = (ph >= 2 && ph <= 4) && q.size() == 0 && (ph != 3 || mem_ready);
    pcs = 2'd0;
    if (fin && ph == 2 && mop == BR && branch_cond) pcs = 2'd1;
    if (fin && ph == 4) pcs = mop == JAL ? 2'd1 : mop == JALR ? 2'd2 : 2'd0;
    aas = (ph == 2) ? (mop == AUI ? 2'd1 : mop == LUI ? 2'd2 : 2'd0) : 2'd0;
    alast = ph == 2 && (mop == OPI || mop == LD || mop == ST || mop == JALR || mop == AUI || mop == LUI);
    wbs = (ph == 4) ? (mop == LD ? 2'd1 : (mop == JAL || mop == JALR) ? 2'd2 : 2'd0) : 2'd0;
    return pk(ph == 0 || ph == 3, ph == 3 && mop == ST, ph == 3, ph == 0 && mem_ready, fin, pcs, aas,
              alast, ph == 4, wbs, fin, ph == 5, 3'(ph));
  endfunction

  function automatic void model_adv();
    if (rst) begin
      ph = 0; mop = '0; q.delete();
    end else if (ph == 0) begin
      if (mem_ready) ph = 1;
    end else if (ph == 1) begin
      mop = opcode;
      q.delete();
      if (!legal(opcode)) ph = 5;
      else begin
        ph = 2;
        if (opcode == LD) q = {3, 4};
        else if (opcode == ST) q = {3};
        else if (opcode != BR && opcode != FEN) q = {4};
      end
    end else if (ph == 2 || ph == 4 || (ph == 3 && mem_ready)) begin
      ph = q.size() != 0 ? q.pop_front() : 0;
    end
  endfunction

  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b (mreq,mwe,mas,irw,pcw,pcs2,aas2,abs,rw,wbs2,ret,ill,st3)",
               nm, cyc, got, want);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] op, input logic bc, input logic mr,
                      input string nm, input logic use_t, input logic [17:0] texp);
    rst = r; opcode = op; branch_cond = bc; mem_ready = mr;
    @(negedge clk);
    check(nm, dut_v, use_t ? texp : model_exp());
    @(posedge clk);
    model_adv();
    cyc++;
    #1;
  endtask

  typedef struct {
    logic r;
    logic [6:0] op;
    logic bc;
    logic mr;
    logic [17:0] exp;
  } vec_t;
  vec_t tab [11];

  initial begin
    ops = '{LD, OPI, AUI, ST, OPR, LUI, BR, JALR, JAL, FEN};
    tab[0]  = '{1, OPR, 0, 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    tab[1]  = '{0, OPR, 0, 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0)};
    tab[2]  = '{0, OPR, 0, 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1)};
    tab[3]  = '{0, OPR, 0, 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,2)};
    tab[4]  = '{0, OPR, 0, 1, pk(0,0,0,0,1,0,0,0,1,0,1,0,4)};
    tab[5]  = '{0, BR,  1, 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0)};
    tab[6]  = '{0, BR,  1, 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1)};
    tab[7]  = '{0, BR,  1, 1, pk(0,0,0,0,1,1,0,0,0,0,1,0,2)};
    tab[8]  = '{0, BR,  0, 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0)};
    tab[9]  = '{0, BR,  0, 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1)};
    tab[10] = '{0, BR,  0, 1, pk(0,0,0,0,1,0,0,0,0,0,1,0,2)};
    clk = 0; rst = 1; opcode = '0; branch_cond = 0; mem_ready = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) step(tab[i].r, tab[i].op, tab[i].bc, tab[i].mr, $sformatf("tab%0d", i), 1, tab[i].exp);
    // LOAD with three MEM wait cycles: 8 cycles total
    step(0, LD, 0, 1, "ld_fetch", 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0));
    step(0, LD, 0, 0, "ld_decode", 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    step(0, LD, 0, 1, "ld_exec", 1, pk(0,0,0,0,0,0,0,1,0,0,0,0,2));
    for (int i = 0; i < 3; i++) step(0, LD, 0, 0, "ld_mem_wait", 1, pk(1,0,1,0,0,0,0,0,0,0,0,0,3));
    step(0, LD, 0, 1, "ld_mem_done", 1, pk(1,0,1,0,0,0,0,0,0,0,0,0,3));
    step(0, LD, 0, 0, "ld_wb", 1, pk(0,0,0,0,1,0,0,0,1,1,1,0,4));
    // JALR
    step(0, JALR, 0, 1, "jalr_fetch", 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0));
    step(0, JALR, 0, 1, "jalr_decode", 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    step(0, 7'h00, 0, 1, "jalr_exec", 1, pk(0,0,0,0,0,0,0,1,0,0,0,0,2));
    step(0, 7'h00, 0, 1, "jalr_wb", 1, pk(0,0,0,0,1,2,0,0,1,2,1,0,4));
    // illegal opcode, sticky trap, reset recovery
    step(0, 7'h7f, 0, 1, "trap_fetch", 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0));
    step(0, 7'h7f, 0, 1, "trap_decode", 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    for (int i = 0; i < 10; i++) step(0, OPR, i[0], 1, "trap_hold", 1, pk(0,0,0,0,0,0,0,0,0,0,0,1,5));
    step(1, OPR, 0, 1, "trap_rst", 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,5));
    step(0, OPR, 0, 0, "trap_recover", 1, pk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    // reset in the middle of a STORE's MEM wait
    step(0, ST, 0, 1, "st_fetch", 1, pk(1,0,0,1,0,0,0,0,0,0,0,0,0));
    step(0, ST, 0, 1, "st_decode", 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,1));
    step(0, ST, 0, 1, "st_exec", 1, pk(0,0,0,0,0,0,0,1,0,0,0,0,2));
    step(0, ST, 0, 0, "st_mem_wait", 1, pk(1,1,1,0,0,0,0,0,0,0,0,0,3));
    step(1, ST, 0, 1, "st_mem_rst", 1, pk(0,0,0,0,0,0,0,0,0,0,0,0,3));
    step(0, ST, 0, 0, "st_refetch", 1, pk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      step($urandom_range(0, 63) == 0, o, 1'($urandom), $urandom_range(0, 9) < 7, "rand", 0, '0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
